// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI receive stage: oversampled frame capture into a FWFT FIFO
//
// Reassembles MSB-first SPI frames from the upstream 16-bit master into parallel
// words, sampled in the clk domain, and queues them behind a valid/ready port.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   spi_CS     chip select, active low (one frame per low period)
//   spi_sclk   SPI clock, idles low, data sampled on its rising edge
//   spiData    serial data, MSB first
//   rx_data    head-of-FIFO word, meaningful while rx_valid = 1
//   rx_valid   FIFO non-empty
//   rx_ready   consumer accepts rx_data when rx_valid & rx_ready
//   bit_cnt    bits received in the current frame (0..DATA_W)
//   fifo_count words currently held in the FIFO
//   frame_err  one-cycle pulse on a malformed frame
//   overflow   one-cycle pulse when a complete word is dropped on a full FIFO
`timescale 1ns/1ps

module spi_slave_rx #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_CS,
    input  logic                          spi_sclk,
    input  logic                          spiData,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [4:0]                    bit_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ARM, IDLE, RECV, DONE} state_t;

    // Synchronisers and one-cycle-delayed copies for edge detection
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_cs_d;
    logic                   r_sclk_d;

    logic w_cs_s, w_sclk_s, w_data_s;
    logic w_sclk_rise, w_cs_rise, w_cs_fall;

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_data_sync <= '0;
            r_cs_d      <= 1'b0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_CS};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], spiData};
            r_cs_d      <= w_cs_s;
            r_sclk_d    <= w_sclk_s;
        end
    end

    // Frame FSM. The shift register holds only DATA_W-1 bits: the last bit is
    // appended directly into the pushed word.
    state_t              r_state;
    logic [DATA_W-2:0]   r_shift;
    logic [4:0]          r_bit_cnt;
    logic                r_frame_err;
    logic                r_err_seen;
    logic                r_push;
    logic [DATA_W-1:0]   r_push_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ARM;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_frame_err <= 1'b0;
            r_err_seen  <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_frame_err <= 1'b0;
            r_push      <= 1'b0;
            case (r_state)
                ARM: begin
                    // Skip any frame already in flight when reset was released
                    if (w_cs_s) r_state <= IDLE;
                end
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state   <= RECV;
                        r_bit_cnt <= '0;
                    end
                end
                RECV: begin
                    // CS rising takes priority over a coincident sclk edge
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= (r_bit_cnt != 5'd0);
                        r_bit_cnt   <= '0;
                    end else if (w_sclk_rise) begin
                        r_shift   <= {r_shift[DATA_W-3:0], w_data_s};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'(DATA_W - 1)) begin
                            r_push      <= 1'b1;
                            r_push_data <= {r_shift, w_data_s};
                            r_err_seen  <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (w_cs_rise) begin
                        r_state   <= IDLE;
                        r_bit_cnt <= '0;
                    end else if (w_sclk_rise && !r_err_seen) begin
                        // Only the first surplus bit of a frame is flagged
                        r_frame_err <= 1'b1;
                        r_err_seen  <= 1'b1;
                    end
                end
                default: r_state <= ARM;
            endcase
        end
    end

    // First-word-fall-through FIFO; a separate count disambiguates full/empty
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic w_pop, w_full, w_wr_en;

    assign rx_valid = (r_count != '0);
    assign w_pop    = rx_valid & rx_ready;
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push
    assign w_wr_en  = r_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_push & w_full & ~w_pop;
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= r_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_data    = r_mem[r_rd_ptr];
    assign bit_cnt    = r_bit_cnt;
    assign fifo_count = r_count;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - scoreboard testbench for spi_slave_rx
`timescale 1ns/1ps

module tb_spi_slave_rx;

    localparam int DATA_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_CS = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spiData = 1'b0;
    logic        rx_ready = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [4:0]  bit_cnt;
    logic [2:0]  fifo_count;
    logic        frame_err;
    logic        overflow;

    spi_slave_rx #(.DATA_W(16), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi_CS(spi_CS), .spi_sclk(spi_sclk),
        .spiData(spiData), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .bit_cnt(bit_cnt), .fifo_count(fifo_count),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q[$];
    int n_pop = 0, n_ferr = 0, n_ovf = 0;
    int p0, f0, o0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every handshake pops one expected word
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 32'd1);
                else                  check("rx_data", 32'(rx_data), sb_q.pop_front());
                n_pop++;
            end
            if (frame_err) n_ferr++;
            if (overflow)  n_ovf++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        spi_CS = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(4);
        spi_CS = 1'b1;
        tick(6);
    endtask

    // Clock n bits MSB first; optionally pop exactly on the cycle the last
    // word is handed to the FIFO (the edge after bit_cnt reaches DATA_W)
    task automatic clock_bits(input logic [31:0] word, input int n, input bit pop_at_end);
        for (int i = 0; i < n; i++) begin
            spiData = word[n-1-i];
            tick(3);
            spi_sclk = 1'b1;
            if (pop_at_end && i == n-1) begin
                int k = 0;
                while (bit_cnt != 5'(DATA_W) && k < 20) begin
                    tick(1);
                    k++;
                end
                check("bit_cnt_at_push", 32'(bit_cnt), 32'(DATA_W));
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
            tick(3);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input int n, input bit pop_at_end);
        cs_low();
        clock_bits(word, n, pop_at_end);
        tick(3);
        check("bit_cnt_before_cs_rise", 32'(bit_cnt), 32'((n > DATA_W) ? DATA_W : n));
        cs_high();
    endtask

    task automatic drain();
        int k = 0;
        rx_ready = 1'b1;
        while ((fifo_count != 0 || rx_valid) && k < 100) begin
            tick(1);
            k++;
        end
        tick(2);
        rx_ready = 1'b0;
        check("fifo_count_after_drain", 32'(fifo_count), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bit_cnt"},    32'(bit_cnt),    32'd0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_rx_valid"},   32'(rx_valid),   32'd0);
        check({tag, "_rx_data"},    32'(rx_data),    32'd0);
        check({tag, "_frame_err"},  32'(frame_err),  32'd0);
        check({tag, "_overflow"},   32'(overflow),   32'd0);
    endtask

    initial begin
        reset = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(6);

        // Single frame with consumer always ready
        rx_ready = 1'b1;
        p0 = n_pop; f0 = n_ferr; o0 = n_ovf;
        sb_q.push_back(32'hA5C3);
        send_frame(32'hA5C3, 16, 1'b0);
        tick(5);
        rx_ready = 1'b0;
        check("t1_handshakes", 32'(n_pop - p0), 32'd1);
        check("t1_frame_err", 32'(n_ferr - f0), 32'd0);
        check("t1_overflow", 32'(n_ovf - o0), 32'd0);

        // Fill, then overflow on the fifth frame
        for (int w = 1; w <= 4; w++) begin
            sb_q.push_back(32'(w));
            send_frame(32'(w), 16, 1'b0);
        end
        check("t2_fifo_full", 32'(fifo_count), 32'd4);
        check("t2_rx_data_head", 32'(rx_data), 32'h0001);
        o0 = n_ovf;
        send_frame(32'h0005, 16, 1'b0);
        tick(3);
        check("t2_overflow_pulses", 32'(n_ovf - o0), 32'd1);
        check("t2_fifo_after_ovf", 32'(fifo_count), 32'd4);
        p0 = n_pop;
        drain();
        check("t2_handshakes", 32'(n_pop - p0), 32'd4);

        // Full FIFO, push coincides with a pop
        for (int w = 1; w <= 4; w++) begin
            sb_q.push_back(32'(w * 32'h1111));
            send_frame(32'(w * 32'h1111), 16, 1'b0);
        end
        check("t3_fifo_full", 32'(fifo_count), 32'd4);
        o0 = n_ovf;
        sb_q.push_back(32'h5555);
        send_frame(32'h5555, 16, 1'b1);
        check("t3_fifo_count", 32'(fifo_count), 32'd4);
        check("t3_overflow", 32'(n_ovf - o0), 32'd0);
        drain();

        // Short frame of 9 bits, then a good frame
        f0 = n_ferr;
        send_frame(32'h15A, 9, 1'b0);
        check("t4_frame_err", 32'(n_ferr - f0), 32'd1);
        check("t4_fifo_unchanged", 32'(fifo_count), 32'd0);
        rx_ready = 1'b1;
        sb_q.push_back(32'h1234);
        send_frame(32'h1234, 16, 1'b0);
        tick(5);
        rx_ready = 1'b0;
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // 17 bits: word queued, one frame_err for the surplus bit
        f0 = n_ferr;
        rx_ready = 1'b1;
        sb_q.push_back(32'hFFFF);
        send_frame(32'h1FFFF, 17, 1'b0);
        tick(5);
        rx_ready = 1'b0;
        check("t5_frame_err", 32'(n_ferr - f0), 32'd1);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset mid-frame, released with CS still low
        cs_low();
        clock_bits(32'hAB, 8, 1'b0);
        reset = 1'b1;
        tick(2);
        check_reset_outputs("t6_in_reset");
        reset = 1'b0;
        f0 = n_ferr; o0 = n_ovf;
        clock_bits(32'hCD, 8, 1'b0);
        cs_high();
        check("t6_fifo_count", 32'(fifo_count), 32'd0);
        check("t6_rx_valid", 32'(rx_valid), 32'd0);
        check("t6_bit_cnt", 32'(bit_cnt), 32'd0);
        check("t6_frame_err", 32'(n_ferr - f0), 32'd0);
        check("t6_overflow", 32'(n_ovf - o0), 32'd0);
        rx_ready = 1'b1;
        p0 = n_pop;
        sb_q.push_back(32'hBEEF);
        send_frame(32'hBEEF, 16, 1'b0);
        tick(5);
        rx_ready = 1'b0;
        check("t6_handshakes", 32'(n_pop - p0), 32'd1);
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI receive stage that sits directly downstream of the team's 16-bit SPI master transmitter. It consumes that block's `spi_CS`, `spi_sclk` and `spiData` lines and reassembles each frame into a parallel word. It oversamples the SPI lines in the system `clk` domain and queues complete words in a small FIFO. A valid/ready handshake presents the queued words to the consumer.

## Interface
Parameters:
- DATA_W, 16, bits per frame; the upstream master sends MSB first.
- FIFO_DEPTH, 4, words buffered; must be a power of two and at least 2.
- SYNC_STAGES, 2, synchroniser flops on each SPI input; minimum 2.

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- spi_CS  in  1  chip select, active low; one frame per low period.
- spi_sclk  in  1  SPI clock; idles low; data is sampled on its rising edge.
- spiData  in  1  serial data, MSB first.
- rx_data  out  DATA_W  head-of-FIFO word; valid only while rx_valid=1.
- rx_valid  out  1  FIFO is non-empty.
- rx_ready  in  1  consumer accepts rx_data on a cycle where rx_valid & rx_ready.
- bit_cnt  out  5  bits received in the current frame, 0..16.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words in the FIFO.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- overflow  out  1  one-cycle pulse when a complete word is dropped because the FIFO is full.

## Operation
- Each of `spi_CS`, `spi_sclk` and `spiData` passes through its own SYNC_STAGES-flop synchroniser.
- `sclk_rise` = synchronised sclk & ~(synchronised sclk delayed one cycle).
- `cs_fall` and `cs_rise` are derived from the synchronised CS in the same way.

FSM states:
- ARM: wait for synchronised CS = 1. This is the state out of reset.
  - CS = 1 → IDLE.
  - Consequence: a frame already in progress when reset deasserts is never captured.
- IDLE: cs_fall → RECV, with bit_cnt cleared to 0.
- RECV: on each sclk_rise, shift the sampled data in at the LSB and increment bit_cnt.
  - On the sclk_rise that brings bit_cnt to DATA_W, the complete word (shift register plus the incoming bit) is pushed to the FIFO in the same cycle → DONE.
  - cs_rise with bit_cnt = 0 → IDLE, with no flags.
  - cs_rise with bit_cnt in 1..DATA_W-1 → IDLE, frame_err pulse, partial word discarded.
- DONE: wait for cs_rise → IDLE, with bit_cnt cleared.
  - Any sclk_rise while in DONE asserts one frame_err pulse per frame; the extra bits are ignored.
- If cs_rise and sclk_rise occur in the same cycle, cs_rise wins and the bit is not sampled.

FIFO:
- First-word fall-through: rx_data equals the head entry whenever rx_valid = 1.
- Push when full and no pop in that cycle: the word is dropped, overflow pulses, and FIFO contents are unchanged.
- Push and pop in the same cycle when full: both succeed, no overflow, fifo_count is unchanged.
- Push and pop in the same cycle when empty: not possible, because pop requires rx_valid.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_count is kept separately so that full and empty are unambiguous.

## Timing
Reset values (asynchronous):
- bit_cnt = 0, fifo_count = 0, rx_valid = 0, rx_data = 0, frame_err = 0, overflow = 0.
- FSM = ARM; synchronisers = 0; pointers = 0.

Latency and constraints:
- With SYNC_STAGES = 2, the sample is captured 3 clk edges after the spi_sclk pin rises. In general, pin-to-capture latency is SYNC_STAGES + 1 edges.
- spiData must be stable across that window. The upstream master changes data on its falling edge, which satisfies this when the next constraint holds.
- The spi_sclk high and low phases must each be at least 2 clk periods, i.e. f_sclk ≤ f_clk/4. The CS high time between frames must be at least 3 clk periods.
- rx_valid rises on the clk edge after the push edge.
- A pop on edge N updates rx_data and rx_valid on edge N, with no bubble.
- frame_err and overflow are registered and high for exactly one cycle.

## Test plan
- Single frame 0xA5C3 with rx_ready = 1 → exactly one handshake with rx_data = 0xA5C3; bit_cnt reads 16 until CS rises; no flags.
- Five back-to-back frames 0x0001..0x0005 with rx_ready = 0 → after 4 frames fifo_count = 4; the fifth frame produces one overflow pulse. Then raise rx_ready → 0x0001..0x0004 are delivered in order and fifo_count returns to 0.
- FIFO full, with the final sclk_rise of a new frame coinciding with a pop → no overflow, fifo_count stays 4, and the new word is delivered last.
- CS deasserts after 9 bits → one frame_err pulse; FIFO unchanged. The next full frame 0x1234 is received correctly.
- 17 sclk edges within one CS-low period carrying 0xFFFF plus one extra bit → 0xFFFF is queued and one frame_err pulse occurs.
- Reset asserted after 8 bits, released with CS still low, and the remaining 8 bits clocked → nothing is queued and all outputs are at their reset values. The next complete frame 0xBEEF is received.
